// File: rtl/multicycle_control_pkg.sv
//------------------------------------------------------------------------------
// Module : mips_ctrl_pkg
// Brief  : State encoding, opcode and mux-select constants for the multi-cycle
//          MIPS main control FSM.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
    S_ILLEGAL = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctl_t;

  // True on the cycle that completes an instruction and leaves for FETCH.
  function automatic logic retires(input state_t s, input logic mem_ready);
    case (s)
      S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_ADDIWB: retires = 1'b1;
      S_MEMWR:                                    retires = mem_ready;
      default:                                    retires = 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_control_if.sv
//------------------------------------------------------------------------------
// Module : multicycle_control_if
// Brief  : Control bus between the main control FSM and the datapath.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface multicycle_control_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             PCWrite;
  logic             PCWriteCond;
  logic             IorD;
  logic             MemRead;
  logic             MemWrite;
  logic             IRWrite;
  logic             MemtoReg;
  logic             RegDst;
  logic             RegWrite;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUOp;
  logic [1:0]       PCSource;
  logic             illegal_op;
  logic [3:0]       state_dbg;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op,
           state_dbg, retired
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op,
           state_dbg, retired
  );
endinterface

`default_nettype wire

// File: rtl/multicycle_control.sv
//------------------------------------------------------------------------------
// Module : multicycle_control
// Brief  : Moore main-control FSM for the multi-cycle MIPS datapath with a
//          retired-instruction counter.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  wire logic            clk,
  input  wire logic            reset,
  multicycle_control_if.master bus
);

  state_t           r_state;
  state_t           w_next;
  ctl_t             w_ctl;
  ctl_t             w_out;
  logic             w_retire;
  logic [CNT_W-1:0] r_retired;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = S_FETCH;
    w_ctl  = '0;
    case (r_state)
      S_FETCH: begin
        w_ctl.mem_read  = 1'b1;
        w_ctl.alu_src_b = SRCB_FOUR;
        w_ctl.alu_op    = ALUOP_ADD;
        w_ctl.pc_source = PCSRC_ALU;
        w_ctl.ir_write  = bus.mem_ready;
        w_ctl.pc_write  = bus.mem_ready;
        w_next          = bus.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Branch target is precomputed here while the opcode is decoded.
        w_ctl.alu_src_b = SRCB_IMM_SH2;
        w_ctl.alu_op    = ALUOP_ADD;
        case (bus.opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXEC;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          OP_ADDI:      w_next = S_ADDIEX;
          default:      w_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        w_ctl.alu_src_a = 1'b1;
        w_ctl.alu_src_b = SRCB_IMM;
        w_ctl.alu_op    = ALUOP_ADD;
        w_next          = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        w_ctl.mem_read = 1'b1;
        w_ctl.i_or_d   = 1'b1;
        w_next         = bus.mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        w_ctl.mem_to_reg = 1'b1;
        w_ctl.reg_write  = 1'b1;
        w_next           = S_FETCH;
      end
      S_MEMWR: begin
        w_ctl.mem_write = 1'b1;
        w_ctl.i_or_d    = 1'b1;
        w_next          = bus.mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        w_ctl.alu_src_a = 1'b1;
        w_ctl.alu_src_b = SRCB_B;
        w_ctl.alu_op    = ALUOP_FUNCT;
        w_next          = S_RWB;
      end
      S_RWB: begin
        w_ctl.reg_dst   = 1'b1;
        w_ctl.reg_write = 1'b1;
        w_next          = S_FETCH;
      end
      S_BRANCH: begin
        w_ctl.alu_src_a     = 1'b1;
        w_ctl.alu_src_b     = SRCB_B;
        w_ctl.alu_op        = ALUOP_SUB;
        w_ctl.pc_write_cond = 1'b1;
        w_ctl.pc_source     = PCSRC_ALUOUT;
        w_next              = S_FETCH;
      end
      S_JUMP: begin
        w_ctl.pc_write  = 1'b1;
        w_ctl.pc_source = PCSRC_JUMP;
        w_next          = S_FETCH;
      end
      S_ADDIEX: begin
        w_ctl.alu_src_a = 1'b1;
        w_ctl.alu_src_b = SRCB_IMM;
        w_ctl.alu_op    = ALUOP_ADD;
        w_next          = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_ctl.reg_write = 1'b1;
        w_next          = S_FETCH;
      end
      S_ILLEGAL: begin
        w_ctl.illegal_op = 1'b1;
        w_next           = S_FETCH;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  // Reset masks every strobe so an abandoned instruction never writes.
  assign w_out    = reset ? '0 : w_ctl;
  assign w_retire = retires(r_state, bus.mem_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_retired <= '0;
    end else if (w_retire) begin
      r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign bus.PCWrite     = w_out.pc_write;
  assign bus.PCWriteCond = w_out.pc_write_cond;
  assign bus.IorD        = w_out.i_or_d;
  assign bus.MemRead     = w_out.mem_read;
  assign bus.MemWrite    = w_out.mem_write;
  assign bus.IRWrite     = w_out.ir_write;
  assign bus.MemtoReg    = w_out.mem_to_reg;
  assign bus.RegDst      = w_out.reg_dst;
  assign bus.RegWrite    = w_out.reg_write;
  assign bus.ALUSrcA     = w_out.alu_src_a;
  assign bus.ALUSrcB     = w_out.alu_src_b;
  assign bus.ALUOp       = w_out.alu_op;
  assign bus.PCSource    = w_out.pc_source;
  assign bus.illegal_op  = w_out.illegal_op;
  assign bus.state_dbg   = r_state;
  assign bus.retired     = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
//------------------------------------------------------------------------------
// Module : tb_multicycle_control
// Brief  : Two DUTs (32-bit and 4-bit counters) on shared stimulus, checked
//          against an instruction-level reference model every cycle.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  multicycle_control_if #(.CNT_W(32)) if32 ();
  multicycle_control_if #(.CNT_W(4))  if4 ();

  assign if32.opcode    = opcode;
  assign if32.mem_ready = mem_ready;
  assign if4.opcode     = opcode;
  assign if4.mem_ready  = mem_ready;

  multicycle_control #(.CNT_W(32)) dut32 (.clk(clk), .reset(reset), .bus(if32));
  multicycle_control #(.CNT_W(4))  dut4  (.clk(clk), .reset(reset), .bus(if4));

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,
  //  RegWrite,ALUSrcA,ALUSrcB[1:0],ALUOp[1:0],PCSource[1:0],illegal_op}
  localparam int B_PCW = 16, B_PCWC = 15, B_IORD = 14, B_MR = 13, B_MW = 12;
  localparam int B_IRW = 11, B_M2R = 10, B_RD = 9, B_RW = 8, B_ILL = 0;

  wire logic [16:0] w_ctl32 = {if32.PCWrite, if32.PCWriteCond, if32.IorD,
    if32.MemRead, if32.MemWrite, if32.IRWrite, if32.MemtoReg, if32.RegDst,
    if32.RegWrite, if32.ALUSrcA, if32.ALUSrcB, if32.ALUOp, if32.PCSource,
    if32.illegal_op};
  wire logic [16:0] w_ctl4 = {if4.PCWrite, if4.PCWriteCond, if4.IorD,
    if4.MemRead, if4.MemWrite, if4.IRWrite, if4.MemtoReg, if4.RegDst,
    if4.RegWrite, if4.ALUSrcA, if4.ALUSrcB, if4.ALUOp, if4.PCSource,
    if4.illegal_op};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: current step plus the remaining steps of the instruction.
  int          m_st = 0;
  int          m_q[$];
  logic [31:0] m_cnt = 0;
  bit          m_valid = 0;

  function automatic logic [16:0] exp_ctl(input int st, input logic rdy);
    logic       pcw = 0, pcwc = 0, iord = 0, mr = 0, mw = 0, irw = 0;
    logic       m2r = 0, rd = 0, rw = 0, sa = 0, ill = 0;
    logic [1:0] sb = 0, op = 0, ps = 0;
    case (st)
      0:  begin mr = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
      1:  sb = 2'b11;
      2:  begin sa = 1; sb = 2'b10; end
      3:  begin mr = 1; iord = 1; end
      4:  begin m2r = 1; rw = 1; end
      5:  begin mw = 1; iord = 1; end
      6:  begin sa = 1; op = 2'b10; end
      7:  begin rd = 1; rw = 1; end
      8:  begin sa = 1; op = 2'b01; pcwc = 1; ps = 2'b01; end
      9:  begin pcw = 1; ps = 2'b10; end
      10: begin sa = 1; sb = 2'b10; end
      11: rw = 1;
      12: ill = 1;
      default: ;
    endcase
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa, sb, op, ps, ill};
  endfunction

  function automatic void load_path(input logic [5:0] op);
    m_q.delete();
    case (op)
      6'b100011: m_q = '{2, 3, 4};
      6'b101011: m_q = '{2, 5};
      6'b000000: m_q = '{6, 7};
      6'b000100: m_q = '{8};
      6'b000010: m_q = '{9};
      6'b001000: m_q = '{10, 11};
      default:   m_q = '{12};
    endcase
  endfunction

  // Inputs change only just after posedge, so negedge values are what the
  // next edge will see: compare now, then advance the model by one edge.
  always @(negedge clk) begin
    logic [16:0] e;
    e = reset ? 17'h0 : exp_ctl(m_st, mem_ready);
    chk("ctl32", 32'(w_ctl32), 32'(e));
    chk("ctl4", 32'(w_ctl4), 32'(e));
    if (m_valid) begin
      chk("state32", 32'(if32.state_dbg), 32'(m_st));
      chk("state4", 32'(if4.state_dbg), 32'(m_st));
      chk("retired32", if32.retired, m_cnt);
      chk("retired4", 32'(if4.retired), {28'h0, m_cnt[3:0]});
    end
    if (reset) begin
      m_st = 0; m_q.delete(); m_cnt = 0; m_valid = 1;
    end else if (m_valid) begin
      if ((m_st == 0 || m_st == 3 || m_st == 5) && !mem_ready) begin
        m_st = m_st;
      end else if (m_st == 0) begin
        m_st = 1;
      end else begin
        if (m_st == 1) load_path(opcode);
        if (m_q.size() == 0) begin
          if (m_st != 12) m_cnt = m_cnt + 1;
          m_st = 0;
        end else begin
          m_st = m_q.pop_front();
        end
      end
    end
  end

  logic [16:0] s_ctl;

  task automatic step(input logic [5:0] op, input logic rdy, input logic rst,
                      input int exp_st, input string nm);
    opcode = op; mem_ready = rdy; reset = rst;
    @(negedge clk);
    s_ctl = w_ctl32;
    chk(nm, 32'(if32.state_dbg), 32'(exp_st));
    @(posedge clk); #1;
  endtask

  int          lw_st[10]  = '{0, 0, 0, 1, 2, 3, 3, 3, 3, 4};
  logic        lw_rdy[10] = '{0, 0, 1, 1, 1, 0, 0, 0, 1, 1};
  logic [5:0]  ops[6]     = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                              6'b000010, 6'b001000};

  initial begin
    reset = 1; opcode = 6'b000000; mem_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 32'(if32.state_dbg), 0);
    chk("reset_retired", if32.retired, 0);
    chk("reset_memread_low", 32'(if32.MemRead), 0);

    // R-type: 0,1,6,7 then FETCH
    step(6'b000000, 1, 0, 0, "rt_s0");
    step(6'b000000, 1, 0, 1, "rt_s1");
    step(6'b000000, 1, 0, 6, "rt_s2");
    chk("rt_exec_aluop", 32'(s_ctl[4:3]), 2);
    step(6'b000000, 1, 0, 7, "rt_s3");
    chk("rt_rwb_regdst", 32'(s_ctl[B_RD]), 1);
    chk("rt_rwb_regwrite", 32'(s_ctl[B_RW]), 1);
    chk("rt_done_state", 32'(if32.state_dbg), 0);
    chk("rt_retired", if32.retired, 1);

    // lw with FETCH and MEMRD waits: 10 cycles
    for (int i = 0; i < 10; i++) begin
      step(6'b100011, lw_rdy[i], 0, lw_st[i], "lw_state");
      if (i < 3) chk("lw_fetch_memread", 32'(s_ctl[B_MR]), 1);
      if (i < 3) chk("lw_fetch_irwrite", 32'(s_ctl[B_IRW]), (i == 2) ? 1 : 0);
      if (lw_st[i] == 3) chk("lw_memrd_iord", 32'(s_ctl[B_IORD]), 1);
      if (i == 9) chk("lw_memwb_memtoreg", 32'(s_ctl[B_M2R]), 1);
    end
    chk("lw_done_state", 32'(if32.state_dbg), 0);
    chk("lw_retired", if32.retired, 2);

    // Illegal opcode
    step(6'b111111, 1, 0, 0, "ill_s0");
    chk("ill_pulse_pre", 32'(s_ctl[B_ILL]), 0);
    step(6'b111111, 1, 0, 1, "ill_s1");
    chk("ill_pulse_pre", 32'(s_ctl[B_ILL]), 0);
    step(6'b111111, 1, 0, 12, "ill_s2");
    chk("ill_pulse", 32'(s_ctl[B_ILL]), 1);
    chk("ill_done_state", 32'(if32.state_dbg), 0);
    chk("ill_pulse_post", 32'(if32.illegal_op), 0);
    chk("ill_retired", if32.retired, 2);

    // sw then beq back-to-back: 7 cycles
    step(6'b101011, 1, 0, 0, "sw_s0");
    step(6'b101011, 1, 0, 1, "sw_s1");
    step(6'b101011, 1, 0, 2, "sw_s2");
    step(6'b101011, 1, 0, 5, "sw_s3");
    chk("sw_memwrite", 32'(s_ctl[B_MW]), 1);
    chk("sw_iord", 32'(s_ctl[B_IORD]), 1);
    step(6'b000100, 1, 0, 0, "beq_s0");
    step(6'b000100, 1, 0, 1, "beq_s1");
    step(6'b000100, 1, 0, 8, "beq_s2");
    chk("beq_aluop", 32'(s_ctl[4:3]), 1);
    chk("beq_pcwritecond", 32'(s_ctl[B_PCWC]), 1);
    chk("beq_pcsource", 32'(s_ctl[2:1]), 1);
    chk("swbeq_retired", if32.retired, 4);

    // Reset while in MEMRD
    step(6'b100011, 1, 0, 0, "rst_s0");
    step(6'b100011, 1, 0, 1, "rst_s1");
    step(6'b100011, 1, 0, 2, "rst_s2");
    step(6'b100011, 0, 0, 3, "rst_s3");
    step(6'b100011, 1, 1, 3, "rst_in_memrd");
    chk("rst_outputs_zero", 32'(s_ctl), 0);
    step(6'b100011, 1, 1, 0, "rst_to_fetch");
    chk("rst_no_regwrite", 32'(s_ctl[B_RW]), 0);
    chk("rst_retired", if32.retired, 0);

    // 16 jumps: 4-bit counter wraps to 0
    for (int i = 0; i < 16; i++) begin
      step(6'b000010, 1, 0, 0, "j_s0");
      step(6'b000010, 1, 0, 1, "j_s1");
      step(6'b000010, 1, 0, 9, "j_s2");
      chk("j_pcwrite", 32'(s_ctl[B_PCW]), 1);
      chk("j_pcsource", 32'(s_ctl[2:1]), 2);
      if (i == 14) chk("j_cnt4_15", 32'(if4.retired), 15);
    end
    chk("j_cnt4_wrap", 32'(if4.retired), 0);
    chk("j_cnt32", if32.retired, 16);

    // Randomized traffic, model-checked every cycle
    for (int c = 0; c < 4000; c++) begin
      if (reset) reset = ($urandom_range(0, 1) == 0);
      else       reset = ($urandom_range(0, 149) == 0);
      if (m_st == 0) begin
        int r;
        r = $urandom_range(0, 7);
        opcode = (r < 6) ? ops[r] : 6'($urandom);
      end
      mem_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
